lpddr_apb_regs: RTL and testbench

APB slave configuration register block for the LPDDR controller; it is the completer on the APB bus that the testbench APB driver and monitor exercise. It decodes APB reads and writes into a small register file and drives static configuration (control, timing) to the controller core. It also runs a mode-register-write (MRW) request/acknowledge handshake toward the controller. Read wait states and MRW back-pressure are inserted through `pready`.

---
 rtl/lpddr_apb_regs_if.sv | 23 ++
 rtl/lpddr_apb_regs.sv | 160 ++++++++++++++++
 tb/tb_lpddr_apb_regs.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lpddr_apb_regs_if.sv
// APB bus bundle between the LPDDR configuration register block and its master.
interface lpddr_apb_regs_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  pready, prdata
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output pready, prdata
  );
endinterface

// File: rtl/lpddr_apb_regs.sv
// APB completer holding the LPDDR controller static configuration (CTRL, TIM0,
// TIM1, SCRATCH), a status view, and the mode-register-write request/ack
// handshake. pready/prdata come straight from flops.
module lpddr_apb_regs #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 1
) (
  input  logic                 pclk,
  input  logic                 preset,
  lpddr_apb_regs_if.slave      apb,
  output logic [31:0]          cfg_ctrl,
  output logic [31:0]          cfg_tim0,
  output logic [31:0]          cfg_tim1,
  output logic                 mrw_req,
  output logic [7:0]           mrw_ma,
  output logic [7:0]           mrw_op,
  input  logic                 mrw_ack,
  input  logic                 init_done
);

  localparam int WW = ADDR_W - 2;
  localparam logic [WW-1:0] A_CTRL    = WW'(0);
  localparam logic [WW-1:0] A_TIM0    = WW'(1);
  localparam logic [WW-1:0] A_TIM1    = WW'(2);
  localparam logic [WW-1:0] A_MRW     = WW'(3);
  localparam logic [WW-1:0] A_STATUS  = WW'(4);
  localparam logic [WW-1:0] A_SCRATCH = WW'(5);
  localparam logic [2:0]    WAIT_LOAD = 3'(RD_WAIT);

  localparam logic [31:0] TIM0_RST = 32'h0A0A_0604;
  localparam logic [31:0] TIM1_RST = 32'h0000_0C30;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_reg;
  logic [WW-1:0]     addr_reg;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rd_cap_reg;
  logic [2:0]        cnt_reg;
  logic [7:0]        mrw_cnt_reg;
  logic [31:0]       scratch_reg;

  logic [DATA_W-1:0] rd_mux;
  logic              wr_mrw;
  logic              blocked;
  logic              commit;
  logic              unused_bits;

  // Byte-lane address bits carry no meaning in this word-only map.
  assign unused_bits = ^apb.paddr[1:0];

  // Read multiplexer over the live register values; sampled at the setup edge.
  always_comb begin
    rd_mux = '0;
    case (apb.paddr[ADDR_W-1:2])
      A_CTRL:    rd_mux = cfg_ctrl;
      A_TIM0:    rd_mux = cfg_tim0;
      A_TIM1:    rd_mux = cfg_tim1;
      A_MRW:     rd_mux = {mrw_req, 15'b0, mrw_ma, mrw_op};
      A_STATUS:  rd_mux = {16'b0, mrw_cnt_reg, 6'b0, mrw_req, init_done};
      A_SCRATCH: rd_mux = scratch_reg;
      default:   rd_mux = '0;
    endcase
  end

  // A new MRW cannot be accepted while one is still outstanding, unless the
  // ack for the outstanding one arrives on this very edge.
  assign wr_mrw  = write_reg && (addr_reg == A_MRW);
  assign blocked = wr_mrw && mrw_req && !mrw_ack;
  assign commit  = (state_reg == ACCESS) && apb.pready && apb.psel &&
                   apb.penable && write_reg;

  // Transfer FSM, register file and MRW handshake.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      rd_cap_reg  <= '0;
      cnt_reg     <= '0;
      apb.pready  <= 1'b0;
      apb.prdata  <= '0;
      cfg_ctrl    <= '0;
      cfg_tim0    <= TIM0_RST;
      cfg_tim1    <= TIM1_RST;
      scratch_reg <= '0;
      mrw_req     <= 1'b0;
      mrw_ma      <= '0;
      mrw_op      <= '0;
      mrw_cnt_reg <= '0;
    end else begin
      // Ack retires the outstanding request first; a committing MRW write
      // on the same edge then re-arms it.
      if (mrw_ack && mrw_req)
        mrw_cnt_reg <= mrw_cnt_reg + 8'd1;
      if (commit && wr_mrw) begin
        mrw_req <= 1'b1;
        mrw_ma  <= wdata_reg[15:8];
        mrw_op  <= wdata_reg[7:0];
      end else if (mrw_ack) begin
        mrw_req <= 1'b0;
      end

      if (commit) begin
        case (addr_reg)
          A_CTRL:    cfg_ctrl    <= wdata_reg;
          A_TIM0:    cfg_tim0    <= wdata_reg;
          A_TIM1:    cfg_tim1    <= wdata_reg;
          A_SCRATCH: scratch_reg <= wdata_reg;
          default:   ;
        endcase
      end

      case (state_reg)
        IDLE: begin
          apb.pready <= 1'b0;
          apb.prdata <= '0;
          if (apb.psel && !apb.penable) begin
            addr_reg   <= apb.paddr[ADDR_W-1:2];
            write_reg  <= apb.pwrite;
            wdata_reg  <= apb.pwdata;
            rd_cap_reg <= rd_mux;
            state_reg  <= SETUP;
          end
        end
        SETUP: begin
          if (!apb.psel) begin
            state_reg <= IDLE;
          end else begin
            state_reg <= ACCESS;
            cnt_reg   <= write_reg ? 3'd0 : WAIT_LOAD;
            if ((write_reg || WAIT_LOAD == 3'd0) && !blocked) begin
              apb.pready <= 1'b1;
              apb.prdata <= write_reg ? '0 : rd_cap_reg;
            end
          end
        end
        ACCESS: begin
          if (!apb.psel || apb.pready) begin
            state_reg  <= IDLE;
            apb.pready <= 1'b0;
            apb.prdata <= '0;
          end else begin
            if (cnt_reg != 3'd0)
              cnt_reg <= cnt_reg - 3'd1;
            if (cnt_reg <= 3'd1 && !blocked) begin
              apb.pready <= 1'b1;
              apb.prdata <= write_reg ? '0 : rd_cap_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr_apb_regs.sv
// Scoreboard bench for lpddr_apb_regs: the driver queues the expected response
// for each transfer, an independent monitor checks every pready it observes.
module tb_lpddr_apb_regs;

  localparam int RD_WAIT = 1;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] cfg_ctrl, cfg_tim0, cfg_tim1;
  logic        mrw_req;
  logic [7:0]  mrw_ma, mrw_op;
  logic        mrw_ack = 1'b0;
  logic        init_done = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          rdy;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  lpddr_apb_regs_if #(.ADDR_W(12), .DATA_W(32)) apb ();

  lpddr_apb_regs #(.ADDR_W(12), .DATA_W(32), .RD_WAIT(RD_WAIT)) dut (
    .pclk(pclk), .preset(preset), .apb(apb),
    .cfg_ctrl(cfg_ctrl), .cfg_tim0(cfg_tim0), .cfg_tim1(cfg_tim1),
    .mrw_req(mrw_req), .mrw_ma(mrw_ma), .mrw_op(mrw_op),
    .mrw_ack(mrw_ack), .init_done(init_done)
  );

  always #5 pclk = ~pclk;

  // Posedge counter used to time pready against the setup edge.
  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: every pready pops one expected response; prdata must be 0 otherwise.
  always @(negedge pclk) begin
    if (apb.pready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pready: got pready=1 prdata=%08h, required no response", apb.prdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (apb.prdata !== e.data) begin
          errors++;
          $display("FAIL %s data: got %08h, required %08h", e.name, apb.prdata, e.data);
        end
        if (e.rdy >= 0) begin
          checks++;
          if (cyc != e.rdy) begin
            errors++;
            $display("FAIL %s latency: pready at cycle %0d, required %0d", e.name, cyc, e.rdy);
          end
        end
        $display("xfer %s prdata=%08h cycle=%0d", e.name, apb.prdata, cyc);
      end
    end else if (apb.prdata !== 32'h0) begin
      checks++;
      errors++;
      $display("FAIL idle_prdata: got %08h while pready=0, required 00000000", apb.prdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end else begin
      $display("check %s = %08h", name, act);
    end
  endtask

  // One APB transfer, entered and left on a negedge. lat < 0 skips the timing check.
  task automatic apb_xfer(input string name, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int lat);
    int n;
    exp_t e;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = wdata;
    @(negedge pclk);
    e.data = exp;
    e.rdy  = (lat < 0) ? -1 : cyc + lat;
    e.name = name;
    sb_q.push_back(e);
    apb.penable = 1'b1;
    n = 0;
    while (apb.pready !== 1'b1 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no pready within 100 cycles, required a response", name);
    end
    @(negedge pclk);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    apb_xfer(name, 1'b0, addr, 32'h0, exp, 1 + RD_WAIT);
  endtask

  task automatic wr(input string name, input logic [11:0] addr, input logic [31:0] data);
    apb_xfer(name, 1'b1, addr, data, 32'h0, 1);
  endtask

  task automatic pulse_ack();
    mrw_ack = 1'b1;
    @(negedge pclk);
    mrw_ack = 1'b0;
    @(negedge pclk);
  endtask

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0;  apb.pwdata = '0;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);

    // Reset state
    chk("rst_pready", {31'b0, apb.pready}, 32'h0);
    chk("rst_mrw_req", {31'b0, mrw_req}, 32'h0);
    chk("rst_ma_op", {16'b0, mrw_ma, mrw_op}, 32'h0);
    chk("rst_ctrl", cfg_ctrl, 32'h0);
    chk("rst_tim0", cfg_tim0, 32'h0A0A_0604);
    chk("rst_tim1", cfg_tim1, 32'h0000_0C30);

    // Read the whole map
    rd("rd_ctrl",    12'h000, 32'h0);
    rd("rd_tim0",    12'h004, 32'h0A0A_0604);
    rd("rd_tim1",    12'h008, 32'h0000_0C30);
    rd("rd_mrw",     12'h00C, 32'h0);
    rd("rd_status",  12'h010, 32'h0000_0001);
    rd("rd_scratch", 12'h014, 32'h0);

    // Scratch write/readback, config outputs untouched
    wr("wr_scratch", 12'h014, 32'hDEAD_BEEF);
    rd("rb_scratch", 12'h017, 32'hDEAD_BEEF);
    chk("scr_ctrl", cfg_ctrl, 32'h0);
    chk("scr_tim0", cfg_tim0, 32'h0A0A_0604);
    chk("scr_tim1", cfg_tim1, 32'h0000_0C30);

    wr("wr_tim1", 12'h008, 32'h0000_1111);
    chk("tim1_upd", cfg_tim1, 32'h0000_1111);

    // MRW handshake, second write stalls until the ack
    wr("wr_mrw1", 12'h00C, 32'h0000_1234);
    chk("mrw1_req", {31'b0, mrw_req}, 32'h1);
    chk("mrw1_ma_op", {16'b0, mrw_ma, mrw_op}, 32'h0000_1234);
    fork
      apb_xfer("wr_mrw2_blocked", 1'b1, 12'h00C, 32'h0000_5678, 32'h0, -1);
      begin
        repeat (5) @(negedge pclk);
        mrw_ack = 1'b1;
        @(negedge pclk);
        mrw_ack = 1'b0;
      end
    join
    chk("mrw2_req", {31'b0, mrw_req}, 32'h1);
    chk("mrw2_ma_op", {16'b0, mrw_ma, mrw_op}, 32'h0000_5678);
    rd("rd_status_busy", 12'h010, 32'h0000_0103);
    rd("rd_mrw_busy", 12'h00C, 32'h8000_5678);
    pulse_ack();
    chk("mrw_done_req", {31'b0, mrw_req}, 32'h0);
    rd("rd_status_cnt2", 12'h010, 32'h0000_0201);
    rd("rd_mrw_idle", 12'h00C, 32'h0000_5678);

    // Unmapped address
    rd("rd_unmapped", 12'h03C, 32'h0);
    wr("wr_unmapped", 12'h03C, 32'hFFFF_FFFF);
    chk("unm_ctrl", cfg_ctrl, 32'h0);
    chk("unm_tim0", cfg_tim0, 32'h0A0A_0604);
    chk("unm_tim1", cfg_tim1, 32'h0000_1111);
    rd("unm_scratch", 12'h014, 32'hDEAD_BEEF);

    // psel dropped during the read wait, then a stray ack
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 12'h004;
    @(negedge pclk);
    apb.penable = 1'b1;
    @(negedge pclk);
    apb.psel = 1'b0; apb.penable = 1'b0;
    repeat (3) @(negedge pclk);
    pulse_ack();
    chk("stray_req", {31'b0, mrw_req}, 32'h0);
    rd("rd_status_stray", 12'h010, 32'h0000_0201);
    rd("rd_tim0_after_abort", 12'h004, 32'h0A0A_0604);

    // Reset in the middle of a CTRL write
    wr("wr_ctrl_aa", 12'h000, 32'h0000_00AA);
    chk("ctrl_aa", cfg_ctrl, 32'h0000_00AA);
    wr("wr_mrw3", 12'h00C, 32'h0000_0101);
    chk("mrw3_req", {31'b0, mrw_req}, 32'h1);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 12'h000; apb.pwdata = 32'h0000_00FF;
    @(negedge pclk);
    preset = 1'b1;
    apb.penable = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge pclk);
    chk("rstx_ctrl", cfg_ctrl, 32'h0);
    chk("rstx_req", {31'b0, mrw_req}, 32'h0);
    rd("rstx_status", 12'h010, 32'h0000_0001);
    wr("wr_ctrl_after_rst", 12'h000, 32'h0000_0005);
    chk("ctrl_after_rst", cfg_ctrl, 32'h0000_0005);
    rd("rd_ctrl_after_rst", 12'h000, 32'h0000_0005);

    repeat (3) @(negedge pclk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
